av2_tile_scheduler: RTL and testbench

Frame-level sequencer for av2_tile_decoder_v2. It walks a frame in raster order of square tiles and drives the decoder's start pulse and per-tile geometry. It waits for tile_done, guards each tile with a watchdog, and reports frame completion or error. It sits between the frame-header parser and the tile decoder.

---
 rtl/av2_sched_pkg.sv | 32 +++
 rtl/av2_sched_watchdog.sv | 35 +++
 rtl/av2_tile_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_av2_tile_scheduler.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/av2_sched_pkg.sv
// Shared types and helpers for the AV2 tile scheduler: FSM state encoding,
// legal tile-size range and the edge-tile clipping function.
package av2_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_NEXT   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } sched_state_e;

  localparam int unsigned TILE_LOG2_MIN = 4;
  localparam int unsigned TILE_LOG2_MAX = 6;

  function automatic logic [2:0] clamp_log2(input logic [2:0] l2);
    if (l2 < 3'(TILE_LOG2_MIN)) return 3'(TILE_LOG2_MIN);
    if (l2 > 3'(TILE_LOG2_MAX)) return 3'(TILE_LOG2_MAX);
    return l2;
  endfunction

  // Tiles on the right/bottom edge shrink to whatever remains of the frame.
  function automatic logic [15:0] clip_dim(input logic [15:0] t,
                                           input logic [15:0] dim,
                                           input logic [15:0] pos);
    logic [15:0] rem;
    rem = dim - pos;
    return (t < rem) ? t : rem;
  endfunction

endpackage

// File: rtl/av2_sched_watchdog.sv
// Per-job watchdog: counts enabled cycles since the last clear; expired_o flags
// the enabled cycle in which the count reaches LIMIT. Latency 0 on expired_o.
module av2_sched_watchdog #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned LIMIT = 10000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/av2_tile_scheduler.sv
// Frame sequencer for the AV2 tile decoder: walks tiles in raster order, pulses tile_start,
// waits for tile_done under a watchdog. tile_start 1 cycle after frame_start, next tile 2 after tile_done.
module av2_tile_scheduler
  import av2_sched_pkg::*;
#(
  parameter int unsigned MAX_WIDTH  = 4096,
  parameter int unsigned MAX_HEIGHT = 2304,
  parameter int unsigned WDOG_WIDTH = 20,
  parameter int unsigned WDOG_LIMIT = 10000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        abort,
  input  logic [15:0] frame_width,
  input  logic [15:0] frame_height,
  input  logic [2:0]  tile_size_log2,
  output logic        tile_start,
  output logic [15:0] tile_x,
  output logic [15:0] tile_y,
  output logic [15:0] tile_w,
  output logic [15:0] tile_h,
  output logic [15:0] tile_idx,
  input  logic        tile_done,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_error,
  output logic [31:0] frame_cycles
);

  sched_state_e state_q, state_d;

  logic [15:0] frm_w_q, frm_w_d;
  logic [15:0] frm_h_q, frm_h_d;
  logic [2:0]  log2_q, log2_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] tw_q, tw_d;
  logic [15:0] th_q, th_d;
  logic [31:0] fc_q, fc_d;

  logic        accept;
  logic        geom_ok;
  logic        wd_clr;
  logic        wd_en;
  logic        wd_expired;
  logic [16:0] tsz17;
  logic [16:0] nx17;
  logic [16:0] ny17;
  logic        row_wrap;
  logic        frame_last;

  assign accept  = (state_q == ST_IDLE) && frame_start;
  assign geom_ok = (frame_width != 16'd0) && (frame_height != 16'd0) &&
                   (frame_width <= 16'(MAX_WIDTH)) && (frame_height <= 16'(MAX_HEIGHT));

  // 17-bit sums so a tile ending exactly at MAX_WIDTH cannot wrap to zero.
  assign tsz17      = 17'd1 << log2_q;
  assign nx17       = {1'b0, x_q} + tsz17;
  assign ny17       = {1'b0, y_q} + tsz17;
  assign row_wrap   = nx17 >= {1'b0, frm_w_q};
  assign frame_last = row_wrap && (ny17 >= {1'b0, frm_h_q});

  assign wd_clr = (state_q == ST_LAUNCH);
  assign wd_en  = (state_q == ST_RUN) && !tile_done;

  av2_sched_watchdog #(
    .WIDTH (WDOG_WIDTH),
    .LIMIT (WDOG_LIMIT)
  ) u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .expired_o (wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (frame_start) state_d = geom_ok ? ST_LAUNCH : ST_ERROR;
      end
      ST_LAUNCH: state_d = ST_RUN;
      ST_RUN: begin
        if (tile_done)       state_d = ST_NEXT;
        else if (wd_expired) state_d = ST_ERROR;
      end
      ST_NEXT:  state_d = frame_last ? ST_DONE : ST_LAUNCH;
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // abort overrides every in-flight transition, including tile_done and expiry
    if (abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  always_comb begin
    logic [15:0] tsz_d;
    frm_w_d = frm_w_q;
    frm_h_d = frm_h_q;
    log2_d  = log2_q;
    x_d     = x_q;
    y_d     = y_q;
    idx_d   = idx_q;
    tw_d    = tw_q;
    th_d    = th_q;
    fc_d    = fc_q;
    tsz_d   = 16'd0;

    if (accept) begin
      frm_w_d = frame_width;
      frm_h_d = frame_height;
      log2_d  = clamp_log2(tile_size_log2);
      if (geom_ok) begin
        x_d   = 16'd0;
        y_d   = 16'd0;
        idx_d = 16'd0;
        fc_d  = 32'd0;
      end
    end else if ((state_q == ST_NEXT) && (state_d == ST_LAUNCH)) begin
      // position only advances into a real LAUNCH so outputs stay on the last tile
      idx_d = idx_q + 16'd1;
      if (row_wrap) begin
        x_d = 16'd0;
        y_d = ny17[15:0];
      end else begin
        x_d = nx17[15:0];
      end
    end

    if (state_q != ST_IDLE) fc_d = fc_q + 32'd1;

    if (state_d == ST_LAUNCH) begin
      tsz_d = 16'd1 << log2_d;
      tw_d  = clip_dim(tsz_d, frm_w_d, x_d);
      th_d  = clip_dim(tsz_d, frm_h_d, y_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_w_q <= 16'd0;
      frm_h_q <= 16'd0;
      log2_q  <= 3'd0;
      x_q     <= 16'd0;
      y_q     <= 16'd0;
      idx_q   <= 16'd0;
      tw_q    <= 16'd0;
      th_q    <= 16'd0;
      fc_q    <= 32'd0;
    end else begin
      frm_w_q <= frm_w_d;
      frm_h_q <= frm_h_d;
      log2_q  <= log2_d;
      x_q     <= x_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      tw_q    <= tw_d;
      th_q    <= th_d;
      fc_q    <= fc_d;
    end
  end

  always_comb begin
    tile_start  = (state_q == ST_LAUNCH);
    busy        = (state_q == ST_LAUNCH) || (state_q == ST_RUN) || (state_q == ST_NEXT);
    frame_done  = (state_q == ST_DONE);
    frame_error = (state_q == ST_ERROR);
  end

  assign tile_x       = x_q;
  assign tile_y       = y_q;
  assign tile_w       = tw_q;
  assign tile_h       = th_q;
  assign tile_idx     = idx_q;
  assign frame_cycles = fc_q;

endmodule

// File: tb/tb_av2_tile_scheduler.sv
// Directed bench for av2_tile_scheduler: expected tiles are queued when a frame
// is started and compared as tile_start pulses appear.
module tb_av2_tile_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic        abort;
  logic [15:0] frame_width;
  logic [15:0] frame_height;
  logic [2:0]  tile_size_log2;
  logic        tile_start;
  logic [15:0] tile_x, tile_y, tile_w, tile_h, tile_idx;
  logic        tile_done;
  logic        busy, frame_done, frame_error;
  logic [31:0] frame_cycles;

  typedef struct {
    int x;
    int y;
    int w;
    int h;
    int idx;
  } tile_t;

  tile_t sbq[$];
  int    cyc = 0;
  int    n_chk = 0;
  int    n_fail = 0;
  int    exp_evt = -1;
  int    start_cyc = 0;
  int    ts_cyc = 0;
  int    fd_cyc = 0;
  int    fe_cyc = 0;
  int    n_ts = 0;
  int    n_fd = 0;
  int    n_fe = 0;

  av2_tile_scheduler #(
    .WDOG_LIMIT (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_start    (frame_start),
    .abort          (abort),
    .frame_width    (frame_width),
    .frame_height   (frame_height),
    .tile_size_log2 (tile_size_log2),
    .tile_start     (tile_start),
    .tile_x         (tile_x),
    .tile_y         (tile_y),
    .tile_w         (tile_w),
    .tile_h         (tile_h),
    .tile_idx       (tile_idx),
    .tile_done      (tile_done),
    .busy           (busy),
    .frame_done     (frame_done),
    .frame_error    (frame_error),
    .frame_cycles   (frame_cycles)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_tiles(input int w, input int h, input int l2);
    int s;
    int t;
    int k;
    tile_t e;
    s = (l2 < 4) ? 4 : ((l2 > 6) ? 6 : l2);
    t = 1 << s;
    k = 0;
    for (int yy = 0; yy < h; yy += t) begin
      for (int xx = 0; xx < w; xx += t) begin
        e.x = xx;
        e.y = yy;
        e.w = (w - xx < t) ? (w - xx) : t;
        e.h = (h - yy < t) ? (h - yy) : t;
        e.idx = k;
        sbq.push_back(e);
        k++;
      end
    end
  endtask

  task automatic compare_tile();
    tile_t e;
    check("sb_nonempty", 32'(sbq.size() != 0), 1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      check("tile_x", 32'(tile_x), e.x);
      check("tile_y", 32'(tile_y), e.y);
      check("tile_w", 32'(tile_w), e.w);
      check("tile_h", 32'(tile_h), e.h);
      check("tile_idx", 32'(tile_idx), e.idx);
    end
    check("busy_in_launch", 32'(busy), 1);
  endtask

  task automatic start_frame(input int w, input int h, input int l2, input bit good);
    @(posedge clk); #1;
    frame_width    = 16'(w);
    frame_height   = 16'(h);
    tile_size_log2 = 3'(l2);
    frame_start    = 1'b1;
    start_cyc      = cyc;
    if (good) begin
      push_tiles(w, h, l2);
      exp_evt = cyc + 1;
    end
    @(negedge clk);
    check("busy_accept_cycle", 32'(busy), 0);
    @(posedge clk); #1;
    frame_start    = 1'b0;
    frame_width    = 16'hFFFF;
    frame_height   = 16'hFFFF;
    tile_size_log2 = 3'd0;
  endtask

  // Observe outputs each negedge; answer tile_start with tile_done `delay` cycles later
  // (delay <= 0: never answer). Stops at frame end or at the stop_after-th tile_start.
  task automatic serve(input int delay, input int stop_after);
    bit fin;
    int ts;
    fin = 1'b0;
    ts  = 0;
    for (int c = 0; c < 2000 && !fin; c++) begin
      @(negedge clk);
      if ((tile_start || frame_done) && exp_evt >= 0) begin
        check("event_cycle", cyc, exp_evt);
        exp_evt = -1;
      end
      if (frame_done) begin
        n_fd++;
        fd_cyc = cyc;
        fin = 1'b1;
      end else if (frame_error) begin
        n_fe++;
        fe_cyc = cyc;
        fin = 1'b1;
      end else if (tile_start) begin
        n_ts++;
        ts_cyc = cyc;
        ts++;
        compare_tile();
        if (stop_after > 0 && ts == stop_after) begin
          fin = 1'b1;
        end else if (delay > 0) begin
          repeat (delay) @(posedge clk);
          #1 tile_done = 1'b1;
          exp_evt = cyc + 2;
          @(posedge clk);
          #1 tile_done = 1'b0;
        end
      end
    end
    check("serve_finished", 32'(fin), 1);
  endtask

  initial begin
    int  ts0, fd0, fe0;
    bit  any_pulse;
    rst_n          = 1'b0;
    frame_start    = 1'b0;
    abort          = 1'b0;
    frame_width    = 16'd0;
    frame_height   = 16'd0;
    tile_size_log2 = 3'd0;
    tile_done      = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_tile_start", 32'(tile_start), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done_err", 32'({frame_done, frame_error}), 0);
    check("rst_geom", 32'(tile_x | tile_y | tile_w | tile_h | tile_idx), 0);
    check("rst_frame_cycles", frame_cycles, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // single 64x64 tile
    fd0 = n_fd;
    start_frame(64, 64, 6, 1'b1);
    serve(5, 0);
    check("single_frame_done", n_fd - fd0, 1);
    check("busy_falls_with_done", 32'(busy), 0);
    check("done_after_tile", fd_cyc - ts_cyc, 7);
    @(negedge clk);
    check("frame_done_one_cycle", 32'(frame_done), 0);
    check("frame_cycles_64", frame_cycles, 8);

    // 100x70 in 32x32 tiles, clipped on right and bottom
    ts0 = n_ts; fd0 = n_fd;
    start_frame(100, 70, 5, 1'b1);
    serve(3, 0);
    check("tiles_100x70", n_ts - ts0, 12);
    check("done_100x70", n_fd - fd0, 1);
    check("sb_drained_100x70", 32'(sbq.size()), 0);
    @(negedge clk);
    check("frame_cycles_100x70", frame_cycles, fd_cyc - start_cyc);

    // illegal geometry
    ts0 = n_ts; fe0 = n_fe;
    start_frame(0, 64, 6, 1'b0);
    serve(1, 0);
    check("err_w0_cycle", fe_cyc - start_cyc, 1);
    start_frame(64, 5000, 6, 1'b0);
    serve(1, 0);
    check("err_h5000_cycle", fe_cyc - start_cyc, 1);
    check("err_count", n_fe - fe0, 2);
    check("err_no_tile_start", n_ts - ts0, 0);

    // log2=2 clamps to 16x16 tiles
    ts0 = n_ts;
    start_frame(32, 16, 2, 1'b1);
    serve(2, 0);
    check("clamp_tiles", n_ts - ts0, 2);

    // watchdog expiry, then tile_done exactly on the limit cycle
    fe0 = n_fe;
    start_frame(64, 64, 6, 1'b1);
    serve(0, 0);
    check("wdog_error", n_fe - fe0, 1);
    check("wdog_error_cycle", fe_cyc - ts_cyc, 17);
    fe0 = n_fe; fd0 = n_fd;
    start_frame(64, 64, 6, 1'b1);
    serve(16, 0);
    check("wdog_limit_no_error", n_fe - fe0, 0);
    check("wdog_limit_done", fd_cyc - ts_cyc, 18);

    // frame_start while busy is ignored; abort during RUN of idx 2
    fd0 = n_fd;
    start_frame(64, 64, 4, 1'b1);
    serve(4, 2);
    @(posedge clk); #1;
    frame_width = 16'd16; frame_height = 16'd16; tile_size_log2 = 3'd4; frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    tile_done = 1'b1;
    exp_evt = cyc + 2;
    @(posedge clk); #1 tile_done = 1'b0;
    serve(4, 1);
    @(posedge clk); #1;
    abort = 1'b1; frame_start = 1'b1;
    @(negedge clk);
    check("busy_before_abort", 32'(busy), 1);
    @(posedge clk); #1;
    abort = 1'b0; frame_start = 1'b0;
    @(negedge clk);
    check("busy_after_abort", 32'(busy), 0);
    any_pulse = 1'b0;
    for (int i = 0; i < 20; i++) begin
      any_pulse = any_pulse | tile_start | frame_done | frame_error | busy;
      @(negedge clk);
    end
    check("quiet_after_abort", 32'(any_pulse), 0);
    check("no_done_after_abort", n_fd - fd0, 0);
    sbq.delete();
    exp_evt = -1;
    start_frame(32, 32, 4, 1'b1);
    serve(3, 0);
    check("restart_done", n_fd - fd0, 1);
    check("sb_drained_restart", 32'(sbq.size()), 0);

    // asynchronous reset in the middle of RUN
    start_frame(64, 64, 4, 1'b1);
    serve(3, 2);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_tile_x", 32'(tile_x), 0);
    check("arst_tile_idx", 32'(tile_idx), 0);
    check("arst_tile_wh", 32'({tile_w, tile_h}), 0);
    check("arst_frame_cycles", frame_cycles, 0);
    sbq.delete();
    exp_evt = -1;
    @(posedge clk); #1 rst_n = 1'b1;

    fd0 = n_fd;
    start_frame(16, 16, 4, 1'b1);
    serve(2, 0);
    check("post_reset_done", n_fd - fd0, 1);
    check("sb_drained_final", 32'(sbq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
